// File: rtl/alu_iterative.sv
// Clocked EX-stage ALU: 1-cycle basic ops plus bit-serial multiply/divide behind Start/Busy/Done.
// Optional signed DIV/REM (opcodes 1100/1101) when ALU_SIGNED_DIV_EN is defined.
module alu_iterative #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WIDTH - 1);

  state_t             state_r;
  logic [CNTW-1:0]    cnt_r;
  logic [3:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [2*WIDTH-1:0] acc_r;
  logic               dz_r;
  logic [WIDTH-1:0]   result_r;
  logic               busy_r;
  logic               done_r;
`ifdef ALU_SIGNED_DIV_EN
  logic               negq_r;
  logic               negr_r;
`endif

  logic [WIDTH-1:0]   alu_s;
  logic [WIDTH-1:0]   sub_s;
  logic               iter_s;
  logic [WIDTH-1:0]   dvd_s;
  logic [WIDTH-1:0]   dvs_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_diff_s;
  logic               is_div_s;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [WIDTH-1:0]   iter_res_s;

  assign sub_s = SrcA + ~SrcB + {{(WIDTH-1){1'b0}}, 1'b1};

  // Single-cycle result from the live operands
  always_comb begin
    alu_s = {WIDTH{1'b0}};
    case (ALUControl)
      4'b0000: alu_s = SrcA + SrcB;
      4'b0001: alu_s = sub_s;
      4'b0010: alu_s = SrcA & SrcB;
      4'b0011: alu_s = SrcA | SrcB;
      4'b0100: alu_s = SrcA ^ SrcB;
      4'b0101: alu_s = ~(SrcA | SrcB);
      4'b0110: alu_s = {{(WIDTH-1){1'b0}}, sub_s[WIDTH-1]};
      4'b0111: alu_s = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      default: alu_s = {WIDTH{1'b0}};
    endcase
  end

  // Operand preparation at accept; signed divides work on magnitudes
  always_comb begin
    iter_s = (ALUControl[3:2] == 2'b10);
    dvd_s  = SrcB;
    dvs_s  = SrcB;
    if (ALUControl[3:1] == 3'b101) begin
      dvd_s = SrcA;
    end else begin
      dvd_s = SrcB;
    end
`ifdef ALU_SIGNED_DIV_EN
    if (ALUControl[3:1] == 3'b110) begin
      iter_s = 1'b1;
      dvd_s  = SrcA[WIDTH-1] ? (~SrcA + {{(WIDTH-1){1'b0}}, 1'b1}) : SrcA;
      dvs_s  = SrcB[WIDTH-1] ? (~SrcB + {{(WIDTH-1){1'b0}}, 1'b1}) : SrcB;
    end else begin
      dvs_s  = SrcB;
    end
`endif
  end

  // One iteration step: acc holds {product_hi, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    is_div_s    = op_r[3] & (op_r[2] | op_r[1]);
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, b_r};
    if (!is_div_s) begin
      acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end else if (div_diff_s[WIDTH]) begin
      acc_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end else begin
      acc_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end
  end

  // Completion-cycle result selection, including divide-by-zero and sign fix-up
  always_comb begin
    iter_res_s = {WIDTH{1'b0}};
    case (op_r)
      4'b1000: iter_res_s = acc_next_s[WIDTH-1:0];
      4'b1001: iter_res_s = acc_next_s[2*WIDTH-1:WIDTH];
      4'b1010: iter_res_s = dz_r ? {WIDTH{1'b1}} : acc_next_s[WIDTH-1:0];
      4'b1011: iter_res_s = dz_r ? a_r : acc_next_s[2*WIDTH-1:WIDTH];
`ifdef ALU_SIGNED_DIV_EN
      4'b1100: iter_res_s = dz_r ? {WIDTH{1'b1}} :
                            negq_r ? (~acc_next_s[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) :
                                     acc_next_s[WIDTH-1:0];
      4'b1101: iter_res_s = dz_r ? a_r :
                            negr_r ? (~acc_next_s[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1}) :
                                     acc_next_s[2*WIDTH-1:WIDTH];
`endif
      default: iter_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Control FSM, operand/accumulator registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= {CNTW{1'b0}};
      op_r     <= 4'b0000;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      dz_r     <= 1'b0;
      result_r <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef ALU_SIGNED_DIV_EN
      negq_r   <= 1'b0;
      negr_r   <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (Start && iter_s) begin
            state_r <= RUN;
            busy_r  <= 1'b1;
            cnt_r   <= {CNTW{1'b0}};
            op_r    <= ALUControl;
            a_r     <= SrcA;
            b_r     <= dvs_s;
            acc_r   <= {{WIDTH{1'b0}}, dvd_s};
            dz_r    <= (SrcB == {WIDTH{1'b0}});
`ifdef ALU_SIGNED_DIV_EN
            negq_r  <= SrcA[WIDTH-1] ^ SrcB[WIDTH-1];
            negr_r  <= SrcA[WIDTH-1];
`endif
          end else if (Start) begin
            result_r <= alu_s;
            done_r   <= 1'b1;
          end
        end
        RUN: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_CNT) begin
            state_r  <= IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            result_r <= iter_res_s;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign ALUResult = result_r;
  assign Busy      = busy_r;
  assign Done      = done_r;

endmodule

// File: doc/alu_iterative.md
Name: alu_iterative

Overview:
- Parametrised, clocked successor to the processor's combinational ALU.
- Keeps the eight basic operations, with a registered 1-cycle result.
- Adds iterative multiply and divide, at one bit per cycle, behind a Start/Busy/Done handshake.
- Sits in the EX stage; the hazard unit stalls the pipeline while Busy=1.

Parameters:
- WIDTH, 32, operand and result width in bits (>=4).
- CNTW, $clog2(WIDTH+1), width of the iteration counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- Start  input  1  operation request; sampled only while Busy=0
- SrcA  input  WIDTH  operand A; latched when Start is accepted
- SrcB  input  WIDTH  operand B; latched when Start is accepted
- ALUControl  input  4  operation select
- ALUResult  output  WIDTH  registered result; holds until the next Done
- Busy  output  1  iterative operation in progress
- Done  output  1  one-cycle pulse; ALUResult is valid in this cycle

Behaviour:
- Opcodes, single-cycle class:
  - 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR; 0101 NOR.
  - 0110 SLT: result = MSB of (SrcA + ~SrcB + 1), zero-extended to WIDTH.
  - 0111 SLTU: unsigned SrcA<SrcB, zero-extended to WIDTH.
  - All arithmetic is modulo 2^WIDTH; no carry or overflow outputs.
- Opcodes, iterative class:
  - 1000 MUL: low WIDTH bits of the unsigned product.
  - 1001 MULHU: high WIDTH bits of the unsigned product.
  - 1010 DIVU: unsigned quotient.
  - 1011 REMU: unsigned remainder.
- Opcodes 1100-1111: see Optional Feature.
- Reset (rst_n=0, any time, including mid-operation):
  - state=IDLE, ALUResult=0, Busy=0, Done=0, counter=0; internal operand/accumulator registers cleared.
  - An in-flight operation is discarded; no Done is produced for it.
- State machine: IDLE, RUN.
- IDLE, Start=1, single-cycle op:
  - Result is computed from the live SrcA/SrcB and registered.
  - Next cycle: Done=1, Busy=0; state stays IDLE.
  - Latency is 1 cycle; back-to-back Starts give one result per cycle.
- IDLE, Start=1, iterative op:
  - Operands are latched, counter=0, state goes to RUN.
  - Start is cycle 0. Busy=1 in cycles 1..WIDTH.
  - In cycle WIDTH+1: Busy=0, Done=1, ALUResult updated, state back to IDLE.
  - Latency is WIDTH+1 cycles.
- Start in the Done cycle is accepted (Busy=0 then).
- Start while Busy=1 is ignored; the current operation is not disturbed.
- Multiply algorithm:
  - Shift-add, one multiplier bit per cycle, LSB first, into a 2*WIDTH accumulator.
  - MUL/MULHU select the low/high half at completion.
- Divide algorithm:
  - Restoring division, one quotient bit per cycle, MSB first, with a WIDTH+1 bit partial remainder.
  - Divide by zero is flagged at accept: DIVU = all ones, REMU = SrcA.
  - Latency is unchanged (still WIDTH+1 cycles).
- Done is a single-cycle pulse only; it is never held.
- ALUResult changes only in a Done cycle or on reset.

Optional Feature:
- Macro: ALU_SIGNED_DIV_EN.
- Defined:
  - 1100 DIV: signed quotient, truncating toward zero.
  - 1101 REM: signed remainder; its sign follows SrcA.
  - Operands are converted to magnitudes at accept. Results are negated as required in the completion cycle, so latency stays WIDTH+1.
  - Divide by zero: DIV = all ones, REM = SrcA.
  - Overflow case (most-negative / -1): DIV = most-negative value, REM = 0.
  - 1110/1111 are reserved.
- Not defined:
  - 1100-1111 are all reserved.
- Reserved opcodes in both builds: single-cycle class, ALUResult=0, Done pulses next cycle.

Test Plan:
- Reset mid-RUN: start MUL 7*9, assert rst_n=0 at cycle 5 -> Busy=0, Done=0, ALUResult=0 immediately; no Done after rst_n is released.
- Single-cycle back-to-back (WIDTH=32): ADD 5+3, then SUB 3-5, then SLTU 3<5 on consecutive cycles -> Done on 3 consecutive cycles with 8, 0xFFFFFFFE, 1; Busy never 1.
- MUL/MULHU: 0xFFFFFFFF*0xFFFFFFFF -> Busy high exactly 32 cycles, Done at cycle 33, MUL=0x00000001; repeat as MULHU -> 0xFFFFFFFE.
- DIVU/REMU: 100/7 -> 14, REMU -> 2; divide by zero 100/0 -> DIVU=0xFFFFFFFF, REMU=100, each at cycle 33.
- Handshake: Start held high with new operands during RUN -> ignored, first result unchanged; the Start in the Done cycle is accepted and Busy rises the next cycle.
- With ALU_SIGNED_DIV_EN: -7/2 -> DIV=-3, REM=-1; 0x80000000/-1 -> DIV=0x80000000, REM=0. Without the macro, 1100 -> result 0 after 1 cycle.
